// File: rtl/sap_pkg.sv
// Shared definitions for the SAP controller: opcodes, T-states and the
// control word that the sequencer presents to the datapath.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_t;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } tstate_t;

  typedef struct packed {
    logic pc_en;
    logic pc_inc;
    logic mar_ld;
    logic mem_en;
    logic ir_ld;
    logic ir_en;
    logic a_ld;
    logic a_en;
    logic b_ld;
    logic adder_en;
    logic sub;
    logic out_ld;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // HALT (and any unused encoding) maps to an all-zero T-state vector
  function automatic logic [5:0] tstate_onehot(input tstate_t s);
    logic [5:0] oh;
    oh = 6'b000000;
    case (s)
      T1:      oh = 6'b000001;
      T2:      oh = 6'b000010;
      T3:      oh = 6'b000100;
      T4:      oh = 6'b001000;
      T5:      oh = 6'b010000;
      T6:      oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/t_state_counter.sv
// Registered T-state ring with run gating and terminal HALT capture.
// Status outputs are masked while reset is held so they drop without a clock.
module t_state_counter
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output tstate_t    state,
  output logic       halted,
  output logic [5:0] tstate
);

  tstate_t state_q;
  tstate_t state_d;

  always_comb begin
    state_d = state_q;
    if (run) begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = (opcode == OP_HLT) ? HALT : T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        HALT:    state_d = HALT;
        default: state_d = T1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T1;
    end else begin
      state_q <= state_d;
    end
  end

  assign state  = state_q;
  assign halted = rst_n && (state_q == HALT);
  assign tstate = rst_n ? tstate_onehot(state_q) : 6'b000000;

endmodule

// File: rtl/control_sequencer.sv
// SAP controller-sequencer: T-state counter plus a combinational decode of
// (state, opcode) into datapath control lines and one-hot bus enables.
module control_sequencer
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_en,
  output logic       pc_inc,
  output logic       mar_ld,
  output logic       mem_en,
  output logic       ir_ld,
  output logic       ir_en,
  output logic       a_ld,
  output logic       a_en,
  output logic       b_ld,
  output logic       adder_en,
  output logic       sub,
  output logic       out_ld,
  output logic       instr_done,
  output logic       halted,
  output logic [5:0] tstate
);

  tstate_t state;
  ctrl_t   ctrl;
  logic    done;

  t_state_counter u_tsc (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .opcode (opcode),
    .state  (state),
    .halted (halted),
    .tstate (tstate)
  );

  // Decode ignores run so a paused state keeps its controls; reset masks all
  always_comb begin
    ctrl = CTRL_IDLE;
    done = 1'b0;
    if (rst_n) begin
      case (state)
        T1: begin
          ctrl.pc_en  = 1'b1;
          ctrl.mar_ld = 1'b1;
        end
        T2: ctrl.pc_inc = 1'b1;
        T3: begin
          ctrl.mem_en = 1'b1;
          ctrl.ir_ld  = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ctrl.ir_en  = 1'b1;
              ctrl.mar_ld = 1'b1;
            end
            OP_OUT: begin
              ctrl.a_en   = 1'b1;
              ctrl.out_ld = 1'b1;
            end
            default: ctrl = CTRL_IDLE;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ctrl.mem_en = 1'b1;
              ctrl.a_ld   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.mem_en = 1'b1;
              ctrl.b_ld   = 1'b1;
              ctrl.sub    = (opcode == OP_SUB);
            end
            default: ctrl = CTRL_IDLE;
          endcase
        end
        T6: begin
          done = (opcode != OP_HLT);
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.adder_en = 1'b1;
            ctrl.a_ld     = 1'b1;
            ctrl.sub      = (opcode == OP_SUB);
          end
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_inc     = ctrl.pc_inc;
  assign mar_ld     = ctrl.mar_ld;
  assign mem_en     = ctrl.mem_en;
  assign ir_ld      = ctrl.ir_ld;
  assign ir_en      = ctrl.ir_en;
  assign a_ld       = ctrl.a_ld;
  assign a_en       = ctrl.a_en;
  assign b_ld       = ctrl.b_ld;
  assign adder_en   = ctrl.adder_en;
  assign sub        = ctrl.sub;
  assign out_ld     = ctrl.out_ld;
  assign instr_done = done;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a phase-counter reference model
// queues the expected control word each cycle and a monitor compares it.
module tb_control_sequencer;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  localparam int PC_EN = 0, PC_INC = 1, MAR_LD = 2, MEM_EN = 3, IR_LD = 4, IR_EN = 5;
  localparam int A_LD = 6, A_EN = 7, B_LD = 8, ADDER_EN = 9, SUB_B = 10, OUT_LD = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       pc_en, pc_inc, mar_ld, mem_en, ir_ld, ir_en;
  logic       a_ld, a_en, b_ld, adder_en, sub, out_ld;
  logic       instr_done, halted;
  logic [5:0] tstate;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [19:0] exp_q[$];
  int          m_phase = 0;
  bit          m_halt = 1'b0;

  control_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .pc_en      (pc_en),
    .pc_inc     (pc_inc),
    .mar_ld     (mar_ld),
    .mem_en     (mem_en),
    .ir_ld      (ir_ld),
    .ir_en      (ir_en),
    .a_ld       (a_ld),
    .a_en       (a_en),
    .b_ld       (b_ld),
    .adder_en   (adder_en),
    .sub        (sub),
    .out_ld     (out_ld),
    .instr_done (instr_done),
    .halted     (halted),
    .tstate     (tstate)
  );

  always #5 clk = ~clk;

  // Expected {tstate, halted, instr_done, controls} for phase 0..5 of an instruction
  function automatic logic [19:0] model_out(input int ph, input bit hl, input bit rst,
                                            input logic [3:0] op);
    logic [11:0] c;
    logic        done;
    logic [5:0]  ts;
    c = '0;
    done = 1'b0;
    if (!rst) return 20'b0;
    if (hl) return {6'b0, 1'b1, 1'b0, 12'b0};
    ts = 6'b000001 << ph;
    case (ph)
      0: begin c[PC_EN] = 1'b1; c[MAR_LD] = 1'b1; end
      1: c[PC_INC] = 1'b1;
      2: begin c[MEM_EN] = 1'b1; c[IR_LD] = 1'b1; end
      3: begin
        if (op == LDA || op == ADD || op == SUB) begin
          c[IR_EN] = 1'b1; c[MAR_LD] = 1'b1;
        end else if (op == OUT) begin
          c[A_EN] = 1'b1; c[OUT_LD] = 1'b1;
        end
      end
      4: begin
        if (op == LDA) begin
          c[MEM_EN] = 1'b1; c[A_LD] = 1'b1;
        end else if (op == ADD || op == SUB) begin
          c[MEM_EN] = 1'b1; c[B_LD] = 1'b1; c[SUB_B] = (op == SUB);
        end
      end
      default: begin
        done = (op != HLT);
        if (op == ADD || op == SUB) begin
          c[ADDER_EN] = 1'b1; c[A_LD] = 1'b1; c[SUB_B] = (op == SUB);
        end
      end
    endcase
    return {ts, 1'b0, done, c};
  endfunction

  // One cycle: drive inputs just after the edge, queue the expectation, advance the model
  task automatic applyStimulus(input bit r, input bit rn, input logic [3:0] op);
    @(posedge clk);
    #1;
    rst_n  = r;
    run    = rn;
    opcode = op;
    exp_q.push_back(model_out(m_phase, m_halt, r, op));
    if (!r) begin
      m_phase = 0;
      m_halt  = 1'b0;
    end else if (!m_halt && rn) begin
      if (m_phase == 3 && op == HLT) m_halt = 1'b1;
      else m_phase = (m_phase + 1) % 6;
    end
  endtask

  task automatic fetch();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)));
  endtask

  task automatic runInstr(input logic [3:0] op);
    fetch();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, op);
  endtask

  task automatic checkOutput(input logic [19:0] expv, input logic [19:0] actv,
                             input logic [4:0] bus_en);
    n_checks++;
    if (actv !== expv) begin
      n_fail++;
      $display("[TB] FAIL outputs t=%0t got %b expected %b", $time, actv, expv);
    end
    n_checks++;
    if ($countones(bus_en) > 1) begin
      n_fail++;
      $display("[TB] FAIL bus_onehot t=%0t got enables %b required at most one high",
               $time, bus_en);
    end
  endtask

  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e, {tstate, halted, instr_done, out_ld, sub, adder_en, b_ld, a_en,
                        a_ld, ir_en, ir_ld, mem_en, mar_ld, pc_inc, pc_en},
                    {pc_en, mem_en, ir_en, a_en, adder_en});
      end
    end
  end

  initial begin : stimulus
    int waited;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    runInstr(ADD);
    runInstr(SUB);
    runInstr(OUT);
    runInstr(4'b0101);

    // LDA paused in T5 for five cycles, then completed
    fetch();
    applyStimulus(1'b1, 1'b1, LDA);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, LDA);
    applyStimulus(1'b1, 1'b1, LDA);
    applyStimulus(1'b1, 1'b1, LDA);

    // LDA abandoned by a reset arriving mid-cycle in T5
    fetch();
    applyStimulus(1'b1, 1'b1, LDA);
    applyStimulus(1'b0, 1'b1, LDA);
    applyStimulus(1'b0, 1'b1, LDA);
    runInstr(ADD);

    // HLT, then twenty cycles of arbitrary run/opcode
    fetch();
    applyStimulus(1'b1, 1'b1, HLT);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    applyStimulus(1'b0, 1'b0, LDA);
    applyStimulus(1'b0, 1'b1, LDA);

    for (int i = 0; i < 10000; i++)
      applyStimulus(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0),
                    4'($urandom_range(0, 15)));

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain got %0d pending expectations required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
